datapath_fwd: RTL and testbench
===============================

Name: datapath_fwd

Overview:
- Parametrised successor to the team's 5-stage MIPS pipelined datapath (IF/ID/EX/MEM/WB), branch resolved in ID.
- Adds a selectable full-forwarding mode, precise stall/flush rules with per-stage valid bits, and stall/retire performance counters.
- Sits between the controller (decodes instr_ID) and the instruction/data memories. Reuses the existing alu, regfile, signext, sl2, adder and mux2 blocks.

Parameters:
- RESET_PC, 32'h0000_0000, pc_IF value on reset.
- FORWARD_EN, 1, 1 = EX/ID forwarding network; 0 = stall-only interlock (legacy behaviour).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr_ID  out  32  instruction in ID, to controller.
- memtoreg_ID, memwrite_ID, alusrc_ID, regdst_ID, regwrite_ID, jump_ID, branch_ID  in  1 each  decoded controls for instr_ID.
- alucontrol_ID  in  3  ALU op for instr_ID.
- pc_IF  out  32  instruction fetch address.
- instr_IF  in  32  fetched instruction, combinational from pc_IF.
- aluout_MEM  out  32  data address.
- writedata_MEM  out  32  store data.
- readdata_MEM  in  32  load data, combinational.
- memwrite_MEM  out  1  store strobe.
- stall_cnt  out  CNT_W  cycles with stall asserted.
- retire_cnt  out  CNT_W  valid instructions completing WB.

Behaviour:
- Reset (async, all outputs immediate):
  - pc_IF=RESET_PC.
  - All pipeline registers cleared to a bubble: instr=0, all controls 0, valid=0.
  - memwrite_MEM=0, aluout_MEM=0, writedata_MEM=0, instr_ID=0, stall_cnt=0, retire_cnt=0.
- Valid bits: IF/ID valid=1 on every normal load. Bubbles and flushes load valid=0. Valid propagates with each stage.
- Latency: an instruction fetched in cycle n writes back in cycle n+4, absent stalls.
- Regfile WB-to-ID bypass: if regwrite_WB && writereg_WB==ra && ra!=0, the ID read returns result_WB in the same cycle.
- Forwarding, FORWARD_EN=1:
  - EX operand A and B (pre-srcb mux) source select, priority MEM > WB > register:
    - MEM when regwrite_MEM && writereg_MEM!=0 && writereg_MEM==rs/rt_EX; source is aluout_MEM.
    - WB under the same match against writereg_WB; source is result_WB.
  - writedata_EX to the MEM stage uses the forwarded B value.
  - ID branch comparator operands are forwarded from aluout_MEM when regwrite_MEM && !memtoreg_MEM && writereg_MEM!=0 matches.
- Stall conditions, FORWARD_EN=1 (rs/rt = instr_ID[25:21]/[20:16], zero register never matches):
  - Load-use: memtoreg_EX && writereg_EX matches rs or rt.
  - Branch on ALU result: branch_ID && regwrite_EX && writereg_EX matches.
  - Branch on load: branch_ID && memtoreg_MEM && writereg_MEM matches.
- Stall conditions, FORWARD_EN=0: stall while regwrite_EX or regwrite_MEM targets a nonzero rs/rt of ID.
- On stall:
  - pc_IF and IF/ID hold.
  - ID/EX loads a bubble.
  - EX/MEM and MEM/WB advance.
- Flush: taken branch (branch_ID && operands equal) or jump_ID, with no stall:
  - pc_IF <= branch target / jump target {pcplus4_ID[31:28], instr_ID[25:0], 2'b00}.
  - IF/ID loads a bubble. One-cycle penalty, no delay slot.
  - Stall has priority over flush; the branch re-evaluates next cycle.
- Writes with writereg=0 are discarded by the regfile and are never a forwarding source.
- stall_cnt increments each cycle stall=1; saturates at all-ones.
- retire_cnt increments each cycle valid_WB=1; saturates at all-ones.
- Reset mid-stall or mid-flush discards all in-flight state and returns to the reset values above.

Decomposition:
- Shared package datapath_pkg holds:
  - struct typedefs if_id_t, id_ex_t, ex_mem_t, mem_wb_t, each including valid.
  - enum fwd_sel_e {FWD_REG, FWD_MEM, FWD_WB}.
  - constant NOP_INSTR=32'h0.
- One sub-module hazard_fwd_unit, purely combinational:
  - computes stall, flush_ID, fwda_EX/fwdb_EX (fwd_sel_e) and fwda_ID/fwdb_ID.
  - parametrised by FORWARD_EN.
- Pipeline registers are written inline in datapath_fwd.

Test Plan:
- Chain addi $1,$0,5; add $2,$1,$1; add $3,$2,$1 -> FORWARD_EN=1: stall_cnt=0, $3=15 (aluout_MEM=15 for add $3). FORWARD_EN=0: same result, stall_cnt=4.
- readdata_MEM=0x11 for lw $4,0($0); add $5,$4,$4 -> exactly 1 stall cycle, add's aluout_MEM=0x22.
- addi $6,$0,1; beq $6,$6,+2 at pc 0x4 -> 1 stall, then pc_IF=0x10, one squashed fetch; retire_cnt counts 2 instructions, not 3.
- j 0x40 at pc 0x8 -> next pc_IF=0x40, fetch from 0xC squashed (valid=0, never retires, memwrite_MEM stays 0).
- addi $0,$0,7; add $7,$0,$0 -> no forwarding selected, aluout_MEM for add=0.
- Assert reset while a load-use stall is active -> same cycle: pc_IF=RESET_PC, memwrite_MEM=0, stall_cnt=0, retire_cnt=0. First fetch after release is from RESET_PC.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared pipeline-register layouts, forwarding select encoding and the ALU for datapath_fwd.
package datapath_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regdst;
        logic [2:0]  alucontrol;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] signimm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic [31:0] aluout;
        logic [31:0] writedata;
        logic [4:0]  writereg;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] readdata;
        logic [31:0] aluout;
        logic [4:0]  writereg;
    } mem_wb_t;

    // ctl[2] inverts B and carries in, so 110 is subtract and 111 is set-less-than.
    function automatic logic [31:0] alu_op(input logic [2:0] ctl, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] bb;
        logic [31:0] sum;
        logic [31:0] res;
        bb  = ctl[2] ? ~b : b;
        sum = a + bb + {31'b0, ctl[2]};
        case (ctl[1:0])
            2'b00:   res = a & bb;
            2'b01:   res = a | bb;
            2'b10:   res = sum;
            default: res = {31'b0, sum[31]};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/datapath_fwd_hazard.sv
// Combinational hazard detection: stall, ID flush and EX/ID forwarding selects.
// FORWARD_EN=0 falls back to a pure interlock that waits for the producer to reach WB.
module hazard_fwd_unit
    import datapath_pkg::*;
#(
    parameter int FORWARD_EN = 1
) (
    input  logic       [4:0] rs_ID,
    input  logic       [4:0] rt_ID,
    input  logic             branch_ID,
    input  logic             jump_ID,
    input  logic             equal_ID,
    input  logic       [4:0] rs_EX,
    input  logic       [4:0] rt_EX,
    input  logic       [4:0] writereg_EX,
    input  logic             regwrite_EX,
    input  logic             memtoreg_EX,
    input  logic       [4:0] writereg_MEM,
    input  logic             regwrite_MEM,
    input  logic             memtoreg_MEM,
    input  logic       [4:0] writereg_WB,
    input  logic             regwrite_WB,
    output logic             stall,
    output logic             flush_ID,
    output fwd_sel_e         fwda_EX,
    output fwd_sel_e         fwdb_EX,
    output fwd_sel_e         fwda_ID,
    output fwd_sel_e         fwdb_ID
);

    // $0 is never a producer, so it can never match a consumer.
    function automatic logic hit(input logic [4:0] w, input logic [4:0] r);
        return (w != 5'd0) && (w == r);
    endfunction

    logic ex_dep_ID;
    logic mem_dep_ID;

    assign ex_dep_ID  = hit(writereg_EX, rs_ID) || hit(writereg_EX, rt_ID);
    assign mem_dep_ID = hit(writereg_MEM, rs_ID) || hit(writereg_MEM, rt_ID);

    always_comb begin
        stall   = 1'b0;
        fwda_EX = FWD_REG;
        fwdb_EX = FWD_REG;
        fwda_ID = FWD_REG;
        fwdb_ID = FWD_REG;
        if (FORWARD_EN != 0) begin
            if (regwrite_MEM && hit(writereg_MEM, rs_EX))     fwda_EX = FWD_MEM;
            else if (regwrite_WB && hit(writereg_WB, rs_EX))  fwda_EX = FWD_WB;
            if (regwrite_MEM && hit(writereg_MEM, rt_EX))     fwdb_EX = FWD_MEM;
            else if (regwrite_WB && hit(writereg_WB, rt_EX))  fwdb_EX = FWD_WB;
            if (regwrite_MEM && !memtoreg_MEM && hit(writereg_MEM, rs_ID)) fwda_ID = FWD_MEM;
            if (regwrite_MEM && !memtoreg_MEM && hit(writereg_MEM, rt_ID)) fwdb_ID = FWD_MEM;
            stall = (memtoreg_EX && ex_dep_ID)
                 || (branch_ID && regwrite_EX && ex_dep_ID)
                 || (branch_ID && memtoreg_MEM && mem_dep_ID);
        end else begin
            stall = (regwrite_EX && ex_dep_ID) || (regwrite_MEM && mem_dep_ID);
        end
        // A stalled branch is re-evaluated next cycle, so it must not redirect now.
        flush_ID = !stall && (jump_ID || (branch_ID && equal_ID));
    end

endmodule

// File: rtl/datapath_fwd.sv
// 5-stage MIPS datapath, branch resolved in ID; fetch-to-writeback is 4 cycles absent stalls.
// Stall holds PC and IF/ID and injects a bubble into EX; a taken branch or jump squashes one fetch.
module datapath_fwd
    import datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FORWARD_EN = 1,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      instr_ID,
    input  logic             memtoreg_ID,
    input  logic             memwrite_ID,
    input  logic             alusrc_ID,
    input  logic             regdst_ID,
    input  logic             regwrite_ID,
    input  logic             jump_ID,
    input  logic             branch_ID,
    input  logic [2:0]       alucontrol_ID,
    output logic [31:0]      pc_IF,
    input  logic [31:0]      instr_IF,
    output logic [31:0]      aluout_MEM,
    output logic [31:0]      writedata_MEM,
    input  logic [31:0]      readdata_MEM,
    output logic             memwrite_MEM,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    if_id_t  if_id;
    id_ex_t  id_ex,  id_ex_d;
    ex_mem_t ex_mem, ex_mem_d;
    mem_wb_t mem_wb, mem_wb_d;

    logic [31:0] rf [32];
    logic        stall, flush_ID;
    fwd_sel_e    fwda_EX, fwdb_EX, fwda_ID, fwdb_ID;

    logic [4:0]  rs_ID, rt_ID, rd_ID, writereg_EX;
    logic [31:0] signimm_ID, rd1_ID, rd2_ID, cmpa_ID, cmpb_ID;
    logic [31:0] pcplus4_IF, pcbranch_ID, pcjump_ID, pcnext_IF;
    logic [31:0] srca_EX, srcb_fwd_EX, srcb_EX, result_WB;
    logic        equal_ID, branch_v_ID, jump_v_ID;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign instr_ID    = if_id.instr;
    assign rs_ID       = instr_ID[25:21];
    assign rt_ID       = instr_ID[20:16];
    assign rd_ID       = instr_ID[15:11];
    assign signimm_ID  = {{16{instr_ID[15]}}, instr_ID[15:0]};
    assign branch_v_ID = branch_ID && if_id.valid;
    assign jump_v_ID   = jump_ID && if_id.valid;
    assign result_WB   = mem_wb.memtoreg ? mem_wb.readdata : mem_wb.aluout;

    // Register file: write at the clock edge, same-cycle WB-to-ID bypass on read.
    always_ff @(posedge clk) begin
        if (mem_wb.regwrite && mem_wb.writereg != 5'd0)
            rf[mem_wb.writereg] <= result_WB;
    end

    assign rd1_ID = (rs_ID == 5'd0) ? 32'd0 :
                    (mem_wb.regwrite && mem_wb.writereg == rs_ID) ? result_WB : rf[rs_ID];
    assign rd2_ID = (rt_ID == 5'd0) ? 32'd0 :
                    (mem_wb.regwrite && mem_wb.writereg == rt_ID) ? result_WB : rf[rt_ID];

    assign cmpa_ID  = (fwda_ID == FWD_MEM) ? ex_mem.aluout : rd1_ID;
    assign cmpb_ID  = (fwdb_ID == FWD_MEM) ? ex_mem.aluout : rd2_ID;
    assign equal_ID = (cmpa_ID == cmpb_ID);

    assign pcplus4_IF  = pc_IF + 32'd4;
    assign pcbranch_ID = if_id.pcplus4 + {signimm_ID[29:0], 2'b00};
    assign pcjump_ID   = {if_id.pcplus4[31:28], instr_ID[25:0], 2'b00};
    assign pcnext_IF   = !flush_ID ? pcplus4_IF : (jump_v_ID ? pcjump_ID : pcbranch_ID);

    hazard_fwd_unit #(.FORWARD_EN(FORWARD_EN)) u_hazard (
        .rs_ID        (rs_ID),
        .rt_ID        (rt_ID),
        .branch_ID    (branch_v_ID),
        .jump_ID      (jump_v_ID),
        .equal_ID     (equal_ID),
        .rs_EX        (id_ex.rs),
        .rt_EX        (id_ex.rt),
        .writereg_EX  (writereg_EX),
        .regwrite_EX  (id_ex.regwrite),
        .memtoreg_EX  (id_ex.memtoreg),
        .writereg_MEM (ex_mem.writereg),
        .regwrite_MEM (ex_mem.regwrite),
        .memtoreg_MEM (ex_mem.memtoreg),
        .writereg_WB  (mem_wb.writereg),
        .regwrite_WB  (mem_wb.regwrite),
        .stall        (stall),
        .flush_ID     (flush_ID),
        .fwda_EX      (fwda_EX),
        .fwdb_EX      (fwdb_EX),
        .fwda_ID      (fwda_ID),
        .fwdb_ID      (fwdb_ID)
    );

    always_comb begin
        id_ex_d = '0;
        if (if_id.valid) begin
            id_ex_d.valid      = 1'b1;
            id_ex_d.regwrite   = regwrite_ID;
            id_ex_d.memtoreg   = memtoreg_ID;
            id_ex_d.memwrite   = memwrite_ID;
            id_ex_d.alusrc     = alusrc_ID;
            id_ex_d.regdst     = regdst_ID;
            id_ex_d.alucontrol = alucontrol_ID;
            id_ex_d.rd1        = rd1_ID;
            id_ex_d.rd2        = rd2_ID;
            id_ex_d.signimm    = signimm_ID;
            id_ex_d.rs         = rs_ID;
            id_ex_d.rt         = rt_ID;
            id_ex_d.rd         = rd_ID;
        end
    end

    assign writereg_EX = id_ex.regdst ? id_ex.rd : id_ex.rt;

    always_comb begin
        case (fwda_EX)
            FWD_MEM: srca_EX = ex_mem.aluout;
            FWD_WB:  srca_EX = result_WB;
            default: srca_EX = id_ex.rd1;
        endcase
        case (fwdb_EX)
            FWD_MEM: srcb_fwd_EX = ex_mem.aluout;
            FWD_WB:  srcb_fwd_EX = result_WB;
            default: srcb_fwd_EX = id_ex.rd2;
        endcase
    end

    assign srcb_EX = id_ex.alusrc ? id_ex.signimm : srcb_fwd_EX;

    always_comb begin
        ex_mem_d           = '0;
        ex_mem_d.valid     = id_ex.valid;
        ex_mem_d.regwrite  = id_ex.regwrite;
        ex_mem_d.memtoreg  = id_ex.memtoreg;
        ex_mem_d.memwrite  = id_ex.memwrite;
        ex_mem_d.aluout    = alu_op(id_ex.alucontrol, srca_EX, srcb_EX);
        ex_mem_d.writedata = srcb_fwd_EX;
        ex_mem_d.writereg  = writereg_EX;

        mem_wb_d           = '0;
        mem_wb_d.valid     = ex_mem.valid;
        mem_wb_d.regwrite  = ex_mem.regwrite;
        mem_wb_d.memtoreg  = ex_mem.memtoreg;
        mem_wb_d.readdata  = readdata_MEM;
        mem_wb_d.aluout    = ex_mem.aluout;
        mem_wb_d.writereg  = ex_mem.writereg;
    end

    assign aluout_MEM    = ex_mem.aluout;
    assign writedata_MEM = ex_mem.writedata;
    assign memwrite_MEM  = ex_mem.memwrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_IF  <= RESET_PC;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            if (!stall)
                pc_IF <= pcnext_IF;
            if (flush_ID) begin
                if_id       <= '0;
                if_id.instr <= NOP_INSTR;
            end else if (!stall) begin
                if_id.valid   <= 1'b1;
                if_id.instr   <= instr_IF;
                if_id.pcplus4 <= pcplus4_IF;
            end
            id_ex  <= stall ? id_ex_t'('0) : id_ex_d;
            ex_mem <= ex_mem_d;
            mem_wb <= mem_wb_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (mem_wb.valid && retire_cnt != '1)
                retire_cnt <= retire_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_datapath_fwd.sv
// Directed bench: forwarding DUT and legacy interlock DUT share one instruction memory and controller model.
module tb_datapath_fwd;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] rdata;
    int          n_cmp, n_bad, cyc;

    logic [31:0] instr_ID, pc_IF, instr_IF, aluout_MEM, writedata_MEM, stall_cnt, retire_cnt;
    logic        memwrite_MEM;
    logic [9:0]  ctl;
    logic [31:0] instr_ID_l, pc_IF_l, instr_IF_l, aluout_MEM_l, writedata_MEM_l, stall_cnt_l, retire_cnt_l;
    logic        memwrite_MEM_l;
    logic [9:0]  ctl_l;

    // Controller model: {memtoreg, memwrite, alusrc, regdst, regwrite, jump, branch, alucontrol[2:0]}
    function automatic logic [9:0] decode(input logic [31:0] ins);
        logic [2:0] f;
        case (ins[5:0])
            6'h22:   f = 3'b110;
            6'h24:   f = 3'b000;
            6'h25:   f = 3'b001;
            6'h2a:   f = 3'b111;
            default: f = 3'b010;
        endcase
        case (ins[31:26])
            6'h00:   return {7'b0001100, f};
            6'h23:   return {7'b1010100, 3'b010};
            6'h2b:   return {7'b0110000, 3'b010};
            6'h04:   return {7'b0000001, 3'b110};
            6'h08:   return {7'b0010100, 3'b010};
            6'h02:   return {7'b0000010, 3'b010};
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs,
                                            input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endfunction

    assign instr_IF   = imem[pc_IF[7:2]];
    assign instr_IF_l = imem[pc_IF_l[7:2]];
    assign ctl        = decode(instr_ID);
    assign ctl_l      = decode(instr_ID_l);

    datapath_fwd #(.RESET_PC(32'h0), .FORWARD_EN(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr_ID(instr_ID),
        .memtoreg_ID(ctl[9]), .memwrite_ID(ctl[8]), .alusrc_ID(ctl[7]), .regdst_ID(ctl[6]),
        .regwrite_ID(ctl[5]), .jump_ID(ctl[4]), .branch_ID(ctl[3]), .alucontrol_ID(ctl[2:0]),
        .pc_IF(pc_IF), .instr_IF(instr_IF), .aluout_MEM(aluout_MEM), .writedata_MEM(writedata_MEM),
        .readdata_MEM(rdata), .memwrite_MEM(memwrite_MEM), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
    );

    datapath_fwd #(.RESET_PC(32'h0), .FORWARD_EN(0), .CNT_W(32)) dut_l (
        .clk(clk), .reset(reset), .instr_ID(instr_ID_l),
        .memtoreg_ID(ctl_l[9]), .memwrite_ID(ctl_l[8]), .alusrc_ID(ctl_l[7]), .regdst_ID(ctl_l[6]),
        .regwrite_ID(ctl_l[5]), .jump_ID(ctl_l[4]), .branch_ID(ctl_l[3]), .alucontrol_ID(ctl_l[2:0]),
        .pc_IF(pc_IF_l), .instr_IF(instr_IF_l), .aluout_MEM(aluout_MEM_l), .writedata_MEM(writedata_MEM_l),
        .readdata_MEM(rdata), .memwrite_MEM(memwrite_MEM_l), .stall_cnt(stall_cnt_l), .retire_cnt(retire_cnt_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    // Leaves the bench in cycle 0: pc_IF=RESET_PC is being fetched.
    task automatic restart();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    logic mw_seen;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rdata = 32'h11;
        clear_imem();

        #1 reset = 1'b1;
        #2;
        check("rst_pc", pc_IF, 32'h0);
        check("rst_instr_id", instr_ID, 32'h0);
        check("rst_memwrite", {31'b0, memwrite_MEM}, 32'h0);
        check("rst_aluout", aluout_MEM, 32'h0);
        check("rst_writedata", writedata_MEM, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        check("rst_retire_cnt", retire_cnt, 32'h0);

        // Dependent ALU chain
        clear_imem();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_add(5'd2, 5'd1, 5'd1);
        imem[2] = enc_add(5'd3, 5'd2, 5'd1);
        restart();
        run_to(3);  check("chain_addi", aluout_MEM, 32'd5);
        run_to(4);  check("chain_add2_mem_fwd", aluout_MEM, 32'd10);
        run_to(5);  check("chain_add3_mem_wb_fwd", aluout_MEM, 32'd15);
        run_to(6);  check("chain_legacy_add2", aluout_MEM_l, 32'd10);
        run_to(9);  check("chain_legacy_add3", aluout_MEM_l, 32'd15);
        run_to(12);
        check("chain_stall_cnt", stall_cnt, 32'd0);
        check("chain_legacy_stall_cnt", stall_cnt_l, 32'd4);

        // Load-use
        clear_imem();
        imem[0] = enc_i(6'h23, 5'd0, 5'd4, 16'd0);
        imem[1] = enc_add(5'd5, 5'd4, 5'd4);
        restart();
        run_to(3);  check("lduse_pc_held", pc_IF, 32'h8);
        run_to(5);  check("lduse_add_result", aluout_MEM, 32'h22);
        run_to(8);  check("lduse_stall_cnt", stall_cnt, 32'd1);

        // Branch on a just-computed register
        clear_imem();
        imem[0] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        imem[1] = enc_i(6'h04, 5'd6, 5'd6, 16'd2);
        imem[2] = enc_i(6'h08, 5'd0, 5'd10, 16'd9);
        imem[4] = enc_i(6'h08, 5'd0, 5'd11, 16'd3);
        restart();
        run_to(3);  check("beq_pc_stalled", pc_IF, 32'h8);
        run_to(4);
        check("beq_pc_target", pc_IF, 32'h10);
        check("beq_squashed_id", instr_ID, 32'h0);
        run_to(8);
        check("beq_retire_2", retire_cnt, 32'd2);
        check("beq_stall_cnt", stall_cnt, 32'd1);
        run_to(9);  check("beq_retire_target", retire_cnt, 32'd3);

        // Jump squashes the store fetched behind it
        clear_imem();
        imem[2] = {6'h02, 26'h10};
        imem[3] = enc_i(6'h2b, 5'd0, 5'd0, 16'd0);
        restart();
        mw_seen = 1'b0;
        run_to(3);  check("j_pc_before", pc_IF, 32'hC);
        run_to(4);  check("j_pc_target", pc_IF, 32'h40);
        while (cyc < 10) begin
            run_to(cyc + 1);
            mw_seen = mw_seen | memwrite_MEM;
            if (cyc == 8) check("j_retire_3", retire_cnt, 32'd3);
        end
        check("j_no_store", {31'b0, mw_seen}, 32'h0);

        // $0 is never a forwarding source
        clear_imem();
        imem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        imem[1] = enc_add(5'd7, 5'd0, 5'd0);
        imem[2] = enc_add(5'd9, 5'd0, 5'd0);
        restart();
        run_to(3);  check("zero_addi_alu", aluout_MEM, 32'd7);
        run_to(4);  check("zero_no_mem_fwd", aluout_MEM, 32'd0);
        run_to(5);  check("zero_no_wb_fwd", aluout_MEM, 32'd0);
        run_to(6);  check("zero_stall_cnt", stall_cnt, 32'd0);

        // Reset asserted during a load-use stall
        clear_imem();
        imem[0] = enc_i(6'h23, 5'd0, 5'd4, 16'd0);
        imem[1] = enc_add(5'd5, 5'd4, 5'd4);
        imem[2] = enc_i(6'h2b, 5'd0, 5'd0, 16'd4);
        imem[3] = enc_i(6'h23, 5'd0, 5'd4, 16'd0);
        imem[4] = enc_add(5'd5, 5'd4, 5'd4);
        restart();
        run_to(6);
        check("midrst_pre_pc", pc_IF, 32'h14);
        check("midrst_pre_memwrite", {31'b0, memwrite_MEM}, 32'h1);
        check("midrst_pre_stall_cnt", stall_cnt, 32'd1);
        check("midrst_pre_retire_cnt", retire_cnt, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst_pc", pc_IF, 32'h0);
        check("midrst_memwrite", {31'b0, memwrite_MEM}, 32'h0);
        check("midrst_stall_cnt", stall_cnt, 32'd0);
        check("midrst_retire_cnt", retire_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        check("midrst_first_fetch", pc_IF, 32'h0);
        run_to(1);
        check("midrst_instr_id", instr_ID, enc_i(6'h23, 5'd0, 5'd4, 16'd0));
        check("midrst_pc_next", pc_IF, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
